// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with a four-state control FSM
//            (RESET / RUN / TRAP / HALT), prioritised next-PC selection,
//            misaligned-redirect trapping and halt/resume support.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        misalign_trap,
  output logic [31:0] epc,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_TRAP  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        trap_q, trap_d;

  // Selected redirect destination: jump beats branch; jump bit 0 is dropped
  // before the alignment check, as JALR semantics require.
  logic        redirect;
  logic [31:0] redirect_tgt;

  assign redirect     = jump | branch_taken;
  assign redirect_tgt = jump ? (jump_target & 32'hFFFF_FFFE) : branch_target;

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign pc_valid      = (state_q == S_RUN);
  assign misalign_trap = trap_q;
  assign epc           = epc_q;
  assign state         = state_q;

  // Next-state and next-PC selection; trap pulse defaults low every cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    trap_d  = 1'b0;
    case (state_q)
      S_RESET: begin
        pc_d    = RESET_VECTOR;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (stall) begin
          // Hold: any redirect this cycle will be re-presented by its source.
          pc_d = pc_q;
        end else if (redirect) begin
          if (redirect_tgt[1:0] != 2'b00) begin
            epc_d   = pc_q;
            trap_d  = 1'b1;
            state_d = S_TRAP;
          end else begin
            pc_d = redirect_tgt;
          end
        end else begin
          pc_d = pc_plus4;
        end
      end
      S_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = S_RUN;
      end
      S_HALT: begin
        if (resume) begin
          pc_d    = pc_plus4;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RESET;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // State registers; reset overrides everything, including TRAP and HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'h0000_0000;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      trap_q  <= trap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer: directed walk through the
//            reference scenario followed by randomised traffic, all compared
//            against a behavioural model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, halt_req, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        pc_valid, misalign_trap;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: states use the externally visible encoding.
  int unsigned m_state;
  logic [31:0] m_pc, m_epc;
  logic        m_trap;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .misalign_trap(misalign_trap), .epc(epc), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply the sequencing rules to the model for one clock edge.
  task automatic model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_state = 0; m_pc = RV; m_trap = 1'b0; m_epc = 32'h0;
      return;
    end
    m_trap = 1'b0;
    case (m_state)
      0: begin m_state = 1; m_pc = RV; end
      2: begin m_state = 1; m_pc = TV; end
      3: if (resume) begin m_state = 1; m_pc = m_pc + 32'd4; end
      default: begin
        if (halt_req) m_state = 3;
        else if (stall) m_state = 1;
        else if (jump || branch_taken) begin
          tgt = jump ? {jump_target[31:1], 1'b0} : branch_target;
          if ((tgt % 4) != 0) begin
            m_epc = m_pc; m_trap = 1'b1; m_state = 2;
          end else m_pc = tgt;
        end else m_pc = m_pc + 32'd4;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc",       pc,                    m_pc);
    check("pc_plus4", pc_plus4,              m_pc + 32'd4);
    check("state",    {30'd0, state},        m_state);
    check("pc_valid", {31'd0, pc_valid},     {31'd0, m_state == 1});
    check("trap",     {31'd0, misalign_trap},{31'd0, m_trap});
    check("epc",      epc,                   m_epc);
  endtask

  task automatic idle();
    rst = 0; stall = 0; branch_taken = 0; jump = 0; halt_req = 0; resume = 0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  initial begin
    idle();
    m_state = 0; m_pc = RV; m_epc = 0; m_trap = 0;
    rst = 1;
    step();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_pc", pc, 32'h0);
    rst = 0;
    step(); check("run0_pc", pc, 32'h0); check("run0_valid", {31'd0, pc_valid}, 32'd1);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);

    branch_taken = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h81;
    step(); check("jump_wins", pc, 32'h80);
    idle(); branch_taken = 1; branch_target = 32'h42;
    step(); check("trap_state", {30'd0, state}, 32'd2); check("trap_epc", epc, 32'h80);
    idle();
    step(); check("trap_vec", pc, 32'h100);

    stall = 1; jump = 1; jump_target = 32'h200;
    step(); step(); check("stall_hold", pc, 32'h100);
    idle();
    step(); check("stall_release", pc, 32'h104);

    halt_req = 1;
    step();
    idle(); jump = 1; jump_target = 32'h300; halt_req = 1;
    step(); step(); step(); check("halt_hold", pc, 32'h104);
    idle(); resume = 1;
    step(); check("resume_pc", pc, 32'h108);

    idle(); jump = 1; jump_target = 32'hFFFF_FFFC;
    step();
    idle();
    step(); check("wrap_pc", pc, 32'h0); check("wrap_plus4", pc_plus4, 32'h4);
    halt_req = 1;
    step();
    idle(); rst = 1;
    step(); check("halt_rst_state", {30'd0, state}, 32'd0);
    idle();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      halt_req     = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      branch_target = $urandom();
      jump_target   = $urandom();
      if ($urandom_range(0, 4) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 4) != 0) jump_target[1]     = 1'b0;
      if ($urandom_range(0, 19) == 0) jump_target       = 32'hFFFF_FFFD;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
